// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32-subset controller: opcodes, FSM states, ALU codes.
package mc_ctrl_pkg;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_L = 7'b0000011;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CL_R,
        CL_I,
        CL_B,
        CL_S,
        CL_L
    } op_class_t;

    typedef struct packed {
        op_class_t op_class;
        logic      valid;
    } op_info_t;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode classifier feeding the controller's DECODE/EXEC/MEM steps.
module mc_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_info_t   info
);

    always_comb begin
        info.op_class = CL_R;
        info.valid    = 1'b1;
        case (opcode)
            OP_R:    info.op_class = CL_R;
            OP_I:    info.op_class = CL_I;
            OP_B:    info.op_class = CL_B;
            OP_S:    info.op_class = CL_S;
            OP_L:    info.op_class = CL_L;
            default: info.valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle sequencer for the ADD/ANDI/BNE/SH/LH datapath with memory wait-state timeout.
// Optional MC_PERF_CNT_EN adds retired-instruction and cycle counters.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
`ifdef MC_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src,
    output logic [3:0] alu_control,
    output logic       instr_done,
    output logic       illegal,
    output logic       fault,
`ifdef MC_PERF_CNT_EN
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] cycle_cnt
`else
    output logic [2:0] state
`endif
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t             state_q;
    state_t             state_d;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_d;
    logic               timed_out;
    op_info_t           info;

    mc_op_decode u_dec (
        .opcode (opcode),
        .info   (info)
    );

    // A wait cycle that would bring the count to MEM_TIMEOUT ends the access in FAULT.
    assign timed_out = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign state     = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            wait_cnt <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_d;
        end
    end

    // Moore outputs qualified by mem_ready; gating on reset drops strobes asynchronously.
    always_comb begin
        state_d      = state_q;
        wait_d       = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src      = 1'b0;
        alu_control  = 4'b0000;
        instr_done   = 1'b0;
        illegal      = 1'b0;
        fault        = 1'b0;
        if (!reset) begin
            alu_control = ALU_ADD;
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_DECODE;
                    end else if (timed_out) begin
                        state_d = ST_FAULT;
                    end else begin
                        wait_d = wait_cnt + WAIT_W'(1);
                    end
                end
                ST_DECODE: begin
                    if (info.valid) begin
                        state_d = ST_EXEC;
                    end else begin
                        illegal = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
                ST_EXEC: begin
                    case (info.op_class)
                        CL_R: state_d = ST_WB;
                        CL_I: begin
                            alu_control = ALU_AND;
                            alu_src     = 1'b1;
                            state_d     = ST_WB;
                        end
                        CL_B: begin
                            alu_control = ALU_SUB;
                            pc_src      = 1'b1;
                            pc_write    = ~zero;
                            instr_done  = 1'b1;
                            state_d     = ST_FETCH;
                        end
                        CL_S, CL_L: begin
                            alu_src = 1'b1;
                            state_d = ST_MEM;
                        end
                        default: state_d = ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    alu_src      = 1'b1;
                    mem_we       = (info.op_class == CL_S);
                    if (mem_ready) begin
                        if (info.op_class == CL_S) begin
                            instr_done = 1'b1;
                            state_d    = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end else if (timed_out) begin
                        state_d = ST_FAULT;
                    end else begin
                        wait_d = wait_cnt + WAIT_W'(1);
                    end
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (info.op_class == CL_L);
                    instr_done = 1'b1;
                    state_d    = ST_FETCH;
                end
                ST_FAULT: fault = 1'b1;
                default:  state_d = ST_FETCH;
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_cnt <= '0;
            cycle_cnt   <= '0;
        end else begin
            if (state_q != ST_FAULT) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (instr_done) retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected outputs queued and compared.
// Perf-counter checks are compiled in when MC_PERF_CNT_EN is defined.
module tb_multicycle_controller;
    import mc_ctrl_pkg::*;

    localparam int unsigned TMO = 4;
    localparam int unsigned CW  = 8;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       asel;
        logic       irw;
        logic       pcw;
        logic       pcs;
        logic       rw;
        logic       m2r;
        logic       asrc;
        logic [3:0] aluc;
        logic       done;
        logic       ill;
        logic       flt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
    logic       reg_write, mem_to_reg, alu_src, instr_done, illegal, fault;
    logic [3:0] alu_control;
    logic [2:0] state;
`ifdef MC_PERF_CNT_EN
    logic [CW-1:0] retired_cnt;
    logic [CW-1:0] cycle_cnt;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    multicycle_controller #(
        .MEM_TIMEOUT (TMO)
`ifdef MC_PERF_CNT_EN
        , .CNT_W     (CW)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .alu_src      (alu_src),
        .alu_control  (alu_control),
        .instr_done   (instr_done),
        .illegal      (illegal),
        .fault        (fault),
`ifdef MC_PERF_CNT_EN
        .state        (state),
        .retired_cnt  (retired_cnt),
        .cycle_cnt    (cycle_cnt)
`else
        .state        (state)
`endif
    );

    // Expected-output model per state
    function automatic exp_t base(input logic [2:0] st, input logic [3:0] aluc);
        exp_t e;
        e      = '0;
        e.st   = st;
        e.aluc = aluc;
        return e;
    endfunction

    function automatic exp_t f_zero();
        return base(3'd0, 4'b0000);
    endfunction

    function automatic exp_t f_fetch(input logic r);
        exp_t e = base(3'd0, ALU_ADD);
        e.req = 1'b1;
        e.irw = r;
        e.pcw = r;
        return e;
    endfunction

    function automatic exp_t f_decode(input logic ill);
        exp_t e = base(3'd1, ALU_ADD);
        e.ill = ill;
        return e;
    endfunction

    function automatic exp_t f_exec_r();
        return base(3'd2, ALU_ADD);
    endfunction

    function automatic exp_t f_exec_i();
        exp_t e = base(3'd2, ALU_AND);
        e.asrc = 1'b1;
        return e;
    endfunction

    function automatic exp_t f_exec_b(input logic z);
        exp_t e = base(3'd2, ALU_SUB);
        e.pcs  = 1'b1;
        e.pcw  = ~z;
        e.done = 1'b1;
        return e;
    endfunction

    function automatic exp_t f_exec_sl();
        exp_t e = base(3'd2, ALU_ADD);
        e.asrc = 1'b1;
        return e;
    endfunction

    function automatic exp_t f_mem(input logic s, input logic r);
        exp_t e = base(3'd3, ALU_ADD);
        e.req  = 1'b1;
        e.asel = 1'b1;
        e.asrc = 1'b1;
        e.we   = s;
        e.done = s & r;
        return e;
    endfunction

    function automatic exp_t f_wb(input logic l);
        exp_t e = base(3'd4, ALU_ADD);
        e.rw   = 1'b1;
        e.m2r  = l;
        e.done = 1'b1;
        return e;
    endfunction

    function automatic exp_t f_fault();
        exp_t e = base(3'd7, ALU_ADD);
        e.flt = 1'b1;
        return e;
    endfunction

    task automatic check();
        exp_t  o;
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o.st   = state;
        o.req  = mem_req;
        o.we   = mem_we;
        o.asel = mem_addr_sel;
        o.irw  = ir_write;
        o.pcw  = pc_write;
        o.pcs  = pc_src;
        o.rw   = reg_write;
        o.m2r  = mem_to_reg;
        o.asrc = alu_src;
        o.aluc = alu_control;
        o.done = instr_done;
        o.ill  = illegal;
        o.flt  = fault;
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
    endtask

    task automatic expect_now(input string t, input exp_t e);
        exp_q.push_back(e);
        tag_q.push_back(t);
        check();
    endtask

    // One clock cycle: drive inputs after the edge, compare on the falling edge
    task automatic cyc(input string t, input logic rdy, input logic [6:0] op,
                       input logic z, input exp_t e);
        mem_ready = rdy;
        opcode    = op;
        zero      = z;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

`ifdef MC_PERF_CNT_EN
    task automatic check_perf(input string t, input logic [CW-1:0] r, input logic [CW-1:0] c);
        total++;
        assert (retired_cnt === r) else begin
            bad++;
            $error("FAIL %s_retired observed=%0d expected=%0d", t, retired_cnt, r);
        end
        total++;
        assert (cycle_cnt === c) else begin
            bad++;
            $error("FAIL %s_cycles observed=%0d expected=%0d", t, cycle_cnt, c);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = OP_R;
        zero      = 1'b0;
        #2;
        expect_now("reset_outputs", f_zero());
`ifdef MC_PERF_CNT_EN
        check_perf("reset", '0, '0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;

        cyc("add_fetch", 1'b1, OP_R, 1'b0, f_fetch(1'b1));
        cyc("add_decode", 1'b1, OP_R, 1'b0, f_decode(1'b0));
        cyc("add_exec", 1'b1, OP_R, 1'b0, f_exec_r());
        cyc("add_wb", 1'b1, OP_R, 1'b0, f_wb(1'b0));

        cyc("andi_fetch", 1'b1, OP_I, 1'b0, f_fetch(1'b1));
        cyc("andi_decode", 1'b1, OP_I, 1'b0, f_decode(1'b0));
        cyc("andi_exec", 1'b1, OP_I, 1'b0, f_exec_i());
        cyc("andi_wb", 1'b1, OP_I, 1'b0, f_wb(1'b0));

        cyc("bne_taken0_fetch", 1'b1, OP_B, 1'b1, f_fetch(1'b1));
        cyc("bne_taken0_decode", 1'b1, OP_B, 1'b1, f_decode(1'b0));
        cyc("bne_zero1_exec", 1'b1, OP_B, 1'b1, f_exec_b(1'b1));

        cyc("sh_fetch", 1'b1, OP_S, 1'b0, f_fetch(1'b1));
        cyc("sh_decode", 1'b1, OP_S, 1'b0, f_decode(1'b0));
        cyc("sh_exec", 1'b1, OP_S, 1'b0, f_exec_sl());
        cyc("sh_mem", 1'b1, OP_S, 1'b0, f_mem(1'b1, 1'b1));

        cyc("lh_fetch", 1'b1, OP_L, 1'b0, f_fetch(1'b1));
        cyc("lh_decode", 1'b1, OP_L, 1'b0, f_decode(1'b0));
        cyc("lh_exec", 1'b1, OP_L, 1'b0, f_exec_sl());
        cyc("lh_mem", 1'b1, OP_L, 1'b0, f_mem(1'b0, 1'b1));
        cyc("lh_wb", 1'b1, OP_L, 1'b0, f_wb(1'b1));
`ifdef MC_PERF_CNT_EN
        check_perf("five_instr", CW'(5), CW'(20));
`endif

        cyc("bne_zero0_fetch", 1'b1, OP_B, 1'b0, f_fetch(1'b1));
        cyc("bne_zero0_decode", 1'b1, OP_B, 1'b0, f_decode(1'b0));
        cyc("bne_zero0_exec", 1'b1, OP_B, 1'b0, f_exec_b(1'b0));

        cyc("lhw_fetch", 1'b1, OP_L, 1'b0, f_fetch(1'b1));
        cyc("lhw_decode", 1'b1, OP_L, 1'b0, f_decode(1'b0));
        cyc("lhw_exec", 1'b1, OP_L, 1'b0, f_exec_sl());
        cyc("lhw_mem_wait1", 1'b0, OP_L, 1'b0, f_mem(1'b0, 1'b0));
        cyc("lhw_mem_wait2", 1'b0, OP_L, 1'b0, f_mem(1'b0, 1'b0));
        cyc("lhw_mem_ready", 1'b1, OP_L, 1'b0, f_mem(1'b0, 1'b1));
        cyc("lhw_wb", 1'b1, OP_L, 1'b0, f_wb(1'b1));

        cyc("ill_fetch_wait", 1'b0, 7'b1111111, 1'b0, f_fetch(1'b0));
        cyc("ill_fetch", 1'b1, 7'b1111111, 1'b0, f_fetch(1'b1));
        cyc("ill_decode", 1'b1, 7'b1111111, 1'b0, f_decode(1'b1));
        cyc("ill_next_fetch_wait", 1'b0, OP_S, 1'b0, f_fetch(1'b0));

        cyc("tmo_fetch", 1'b1, OP_S, 1'b0, f_fetch(1'b1));
        cyc("tmo_decode", 1'b1, OP_S, 1'b0, f_decode(1'b0));
        cyc("tmo_exec", 1'b1, OP_S, 1'b0, f_exec_sl());
        for (int i = 0; i < int'(TMO); i++)
            cyc($sformatf("tmo_mem_wait%0d", i), 1'b0, OP_S, 1'b0, f_mem(1'b1, 1'b0));
        cyc("tmo_fault", 1'b0, OP_S, 1'b0, f_fault());
        cyc("tmo_fault_sticky", 1'b1, OP_S, 1'b0, f_fault());

        reset = 1'b1;
        #1;
        expect_now("fault_async_reset", f_zero());
        @(posedge clk);
        #1;
        reset = 1'b0;
`ifdef MC_PERF_CNT_EN
        check_perf("after_reset", '0, '0);
`endif
        cyc("post_fault_fetch", 1'b1, OP_S, 1'b0, f_fetch(1'b1));
        cyc("abort_decode", 1'b1, OP_S, 1'b0, f_decode(1'b0));
        cyc("abort_exec", 1'b1, OP_S, 1'b0, f_exec_sl());

        mem_ready = 1'b0;
        exp_q.push_back(f_mem(1'b1, 1'b0));
        tag_q.push_back("abort_mem");
        @(negedge clk);
        check();
        #2;
        reset = 1'b1;
        #1;
        expect_now("abort_async_reset", f_zero());
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("abort_refetch", 1'b1, OP_R, 1'b0, f_fetch(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
